// File: rtl/colparity_host_if.sv
// Handshake bundle between the column-parity host, its upstream source, the core and the downstream sink.
// slave = host side, master = environment side.
interface colparity_host_if #(
    parameter int Width = 25
);
    logic             inValid;
    logic [Width-1:0] inSlice;
    logic             inReady;
    logic             coreReady;
    logic             coreStart;
    logic             corePutInput;
    logic [Width-1:0] coreMatrixIn;
    logic             coreOutReady;
    logic [Width-1:0] coreMatrixOut;
    logic             outValid;
    logic [Width-1:0] outSlice;
    logic             outAccept;
    logic             busy;

    // Valid/ready: a slice moves only on a cycle where its valid and ready/accept are both high.
    modport slave (
        input  inValid, inSlice, coreReady, corePutInput, coreOutReady,
               coreMatrixOut, outAccept,
        output inReady, coreStart, coreMatrixIn, outValid, outSlice, busy
    );

    modport master (
        output inValid, inSlice, coreReady, corePutInput, coreOutReady,
               coreMatrixOut, outAccept,
        input  inReady, coreStart, coreMatrixIn, outValid, outSlice, busy
    );
endinterface

// File: rtl/colparity_host.sv
// Buffers one Count x Width matrix, streams it through the column-parity core and drains the results.
// Optional COLPARITY_HOST_ERR_EN adds a sticky protoErr output for core protocol violations.
module colparity_host #(
    parameter int Count = 64,
    parameter int Width = 25
) (
    input  logic                clk,
    input  logic                rst,
    colparity_host_if.slave     bus,
`ifdef COLPARITY_HOST_ERR_EN
    output logic                protoErr,
`endif
    output logic [2:0]          dbg_state_o
);
    localparam int CW = (Count > 1) ? $clog2(Count) : 1;
    localparam logic [CW-1:0] LAST = CW'(Count - 1);

    typedef enum logic [2:0] {
        S_FILL    = 3'd0,
        S_WAIT    = 3'd1,
        S_START   = 3'd2,
        S_FEED    = 3'd3,
        S_COLLECT = 3'd4,
        S_DRAIN   = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   fill_cnt_q, fill_cnt_d;
    logic [CW-1:0]   feed_cnt_q, feed_cnt_d;
    logic [CW-1:0]   col_cnt_q, col_cnt_d;
    logic [CW-1:0]   drain_cnt_q, drain_cnt_d;
    logic            collected_q, collected_d;

    logic            in_ready_q;
    logic            core_start_q;
    logic            out_valid_q;
    logic            busy_q;

    logic [Width-1:0] src_mem [Count];
    logic [Width-1:0] res_mem [Count];

    logic in_core_phase;
    logic fill_hs, feed_hs, col_hs, drain_hs;
    logic fill_wrap, feed_wrap, col_wrap, drain_wrap;

    assign in_core_phase = (state_q == S_FEED) || (state_q == S_COLLECT);

    // inReady is high exactly in FILL, so a FILL-state inValid is a handshake.
    assign fill_hs  = (state_q == S_FILL) && bus.inValid;
    assign feed_hs  = (state_q == S_FEED) && bus.corePutInput;
    assign col_hs   = in_core_phase && bus.coreOutReady;
    assign drain_hs = (state_q == S_DRAIN) && bus.outAccept;

    assign fill_wrap  = fill_hs  && (fill_cnt_q  == LAST);
    assign feed_wrap  = feed_hs  && (feed_cnt_q  == LAST);
    assign col_wrap   = col_hs   && (col_cnt_q   == LAST);
    assign drain_wrap = drain_hs && (drain_cnt_q == LAST);

    always_comb begin
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        feed_cnt_d  = feed_cnt_q;
        col_cnt_d   = col_cnt_q;
        drain_cnt_d = drain_cnt_q;
        collected_d = collected_q;

        if (fill_hs)  fill_cnt_d  = fill_wrap  ? '0 : fill_cnt_q  + 1'b1;
        if (feed_hs)  feed_cnt_d  = feed_wrap  ? '0 : feed_cnt_q  + 1'b1;
        if (col_hs)   col_cnt_d   = col_wrap   ? '0 : col_cnt_q   + 1'b1;
        if (drain_hs) drain_cnt_d = drain_wrap ? '0 : drain_cnt_q + 1'b1;

        case (state_q)
            S_FILL: begin
                if (fill_wrap) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.coreReady) state_d = S_START;
            end
            S_START: begin
                state_d = S_FEED;
            end
            S_FEED: begin
                // Results may all arrive before feeding ends; remember that so we skip COLLECT.
                if (col_wrap) collected_d = 1'b1;
                if (feed_wrap) begin
                    state_d = (collected_q || col_wrap) ? S_DRAIN : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (col_wrap) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_wrap) begin
                    state_d     = S_FILL;
                    fill_cnt_d  = '0;
                    feed_cnt_d  = '0;
                    col_cnt_d   = '0;
                    drain_cnt_d = '0;
                    collected_d = 1'b0;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FILL;
            fill_cnt_q   <= '0;
            feed_cnt_q   <= '0;
            col_cnt_q    <= '0;
            drain_cnt_q  <= '0;
            collected_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            core_start_q <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            fill_cnt_q   <= fill_cnt_d;
            feed_cnt_q   <= feed_cnt_d;
            col_cnt_q    <= col_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            collected_q  <= collected_d;
            in_ready_q   <= (state_d == S_FILL);
            core_start_q <= (state_d == S_START);
            out_valid_q  <= (state_d == S_DRAIN);
            busy_q       <= !((state_d == S_FILL) && (fill_cnt_d == '0));
        end
    end

    // Buffers keep their contents across reset.
    always_ff @(posedge clk) begin
        if (!rst && fill_hs) src_mem[fill_cnt_q] <= bus.inSlice;
        if (!rst && col_hs)  res_mem[col_cnt_q]  <= bus.coreMatrixOut;
    end

    assign bus.inReady      = in_ready_q;
    assign bus.coreStart    = core_start_q;
    assign bus.outValid     = out_valid_q;
    assign bus.busy         = busy_q;
    assign bus.coreMatrixIn = (state_q == S_FEED) ? src_mem[feed_cnt_q] : '0;
    assign bus.outSlice     = out_valid_q ? res_mem[drain_cnt_q] : '0;
    assign dbg_state_o      = state_q;

`ifdef COLPARITY_HOST_ERR_EN
    logic proto_err_q;
    logic err_evt;

    assign err_evt = (bus.corePutInput && (state_q != S_FEED))
                  || (bus.coreOutReady && !in_core_phase)
                  || (bus.coreReady && in_core_phase);

    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err_q <= 1'b0;
        end else if (err_evt) begin
            proto_err_q <= 1'b1;
        end
    end

    assign protoErr = proto_err_q;
`endif
endmodule
